// File: rtl/cascade_master_sequencer_if.sv
// rtl/cascade_master_sequencer_if.sv - INTA/cascade bus bundle between CPU-side logic and the master sequencer
//
// Purpose: groups the acknowledge input, the ICW/priority-resolver inputs, and the
// cascade/data-enable outputs of the master-side cascade sequencer.
// Ports (signals):
//   INTA_N         CPU interrupt acknowledge, active low, asynchronous
//   SPEN           1 = master device, 0 = slave device
//   SNGL           ICW1 single mode
//   MODE_8086      1 = 2-pulse sequence, 0 = 3-pulse 8080 sequence
//   ICW3_SLAVES    bit n set: IRn carries a cascaded slave
//   IR_LEVEL       resolved highest-priority level
//   IR_VALID       IR_LEVEL is meaningful
//   CASCADE        slave ID for CAS2..0
//   CAS_OE         CAS tri-state enable
//   MASTER_DATA_EN master drives the data bus during this pulse
//   SEQ_DONE       one-cycle pulse at the end of a full sequence
//   SEQ_ABORT      one-cycle pulse on gap timeout
// Modports: master = sequencer side, slave = surrounding logic / stimulus side.

interface cascade_master_sequencer_if;
  logic       INTA_N;
  logic       SPEN;
  logic       SNGL;
  logic       MODE_8086;
  logic [7:0] ICW3_SLAVES;
  logic [2:0] IR_LEVEL;
  logic       IR_VALID;
  logic [2:0] CASCADE;
  logic       CAS_OE;
  logic       MASTER_DATA_EN;
  logic       SEQ_DONE;
  logic       SEQ_ABORT;

  modport master (
    input  INTA_N, SPEN, SNGL, MODE_8086, ICW3_SLAVES, IR_LEVEL, IR_VALID,
    output CASCADE, CAS_OE, MASTER_DATA_EN, SEQ_DONE, SEQ_ABORT
  );

  modport slave (
    output INTA_N, SPEN, SNGL, MODE_8086, ICW3_SLAVES, IR_LEVEL, IR_VALID,
    input  CASCADE, CAS_OE, MASTER_DATA_EN, SEQ_DONE, SEQ_ABORT
  );
endinterface

// File: rtl/cascade_master_sequencer.sv
// rtl/cascade_master_sequencer.sv - master-side 8259 cascade bus sequencer
//
// Purpose: follows the INTA pulse train (2 pulses in 8086 mode, 3 in 8080 mode),
// latches the resolved IR level at the first pulse, drives the slave ID on the
// cascade lines when that level has a slave attached, and tells the data-bus
// block in which pulses the master itself supplies the data.
// Parameters:
//   SYNC_STAGES    flops in the INTA_N synchronizer (>= 2)
//   TIMEOUT_CYCLES clk cycles INTA_N may stay high between pulses before abort
// Ports:
//   clk    system clock
//   reset  asynchronous active-high reset
//   bus    cascade_master_sequencer_if.master (inputs INTA_N..IR_VALID,
//          registered outputs CASCADE, CAS_OE, MASTER_DATA_EN, SEQ_DONE, SEQ_ABORT)

module cascade_master_sequencer #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  cascade_master_sequencer_if.master     bus
);

  localparam int             CW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    P1   = 3'd1,
    G1   = 3'd2,
    P2   = 3'd3,
    G2   = 3'd4,
    P3   = 3'd5,
    DONE = 3'd6
  } state_t;

  // INTA_N synchronizer plus one edge-detect flop. Reset to the idle (high)
  // level so leaving reset never looks like a falling edge.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   inta_prev;
  logic                   inta_s;
  logic                   fall;
  logic                   rise;

  assign inta_s = sync_q[SYNC_STAGES-1];
  assign fall   = inta_prev & ~inta_s;
  assign rise   = ~inta_prev & inta_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q    <= '1;
      inta_prev <= 1'b1;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], bus.INTA_N};
      inta_prev <= inta_s;
    end
  end

  logic       enabled;
  logic [2:0] new_lvl;
  logic       new_hit;

  assign enabled = bus.SPEN & ~bus.SNGL;
  // A spurious acknowledge resolves to level 7 and never selects a slave.
  assign new_lvl = bus.IR_VALID ? bus.IR_LEVEL : 3'd7;
  assign new_hit = bus.IR_VALID & bus.ICW3_SLAVES[bus.IR_LEVEL];

  // Output values for the state being entered: {CASCADE, CAS_OE, MASTER_DATA_EN}.
  // Computed at the transition so the outputs are registered alongside the state.
  function automatic logic [4:0] drive(state_t s, logic h, logic m, logic [2:0] l);
    logic oe;
    logic mde;
    oe  = h & ((s == P1) | (s == G1) | (s == P2) | (s == G2) | (s == P3));
    mde = 1'b0;
    case (s)
      P1:      mde = ~m;   // 8080 master always sends the CALL opcode
      P2, P3:  mde = ~h;   // vector bytes come from the slave when one is hit
      default: mde = 1'b0;
    endcase
    return {(oe ? l : 3'b000), oe, mde};
  endfunction

  state_t        state;
  logic [2:0]    lvl;
  logic          hit;
  logic          m86;
  logic [CW-1:0] cnt;
  logic [2:0]    cascade_q;
  logic          cas_oe_q;
  logic          mde_q;
  logic          done_q;
  logic          abort_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      lvl       <= 3'd0;
      hit       <= 1'b0;
      m86       <= 1'b0;
      cnt       <= '0;
      cascade_q <= 3'd0;
      cas_oe_q  <= 1'b0;
      mde_q     <= 1'b0;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      if (!enabled && state != IDLE) begin
        // Losing master status mid-sequence drops everything silently.
        state                         <= IDLE;
        cnt                           <= '0;
        {cascade_q, cas_oe_q, mde_q}  <= 5'd0;
      end else begin
        case (state)
          IDLE: begin
            if (enabled && fall) begin
              state                        <= P1;
              lvl                          <= new_lvl;
              hit                          <= new_hit;
              m86                          <= bus.MODE_8086;
              {cascade_q, cas_oe_q, mde_q} <= drive(P1, new_hit, bus.MODE_8086, new_lvl);
            end
          end
          P1: begin
            if (rise) begin
              state                        <= G1;
              cnt                          <= '0;
              {cascade_q, cas_oe_q, mde_q} <= drive(G1, hit, m86, lvl);
            end
          end
          G1, G2: begin
            // A fall wins over a timeout landing on the same cycle.
            if (fall) begin
              state                        <= (state == G1) ? P2 : P3;
              {cascade_q, cas_oe_q, mde_q} <= drive((state == G1) ? P2 : P3, hit, m86, lvl);
            end else if (cnt == CNT_LAST) begin
              state                        <= IDLE;
              cnt                          <= '0;
              abort_q                      <= 1'b1;
              {cascade_q, cas_oe_q, mde_q} <= 5'd0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          P2: begin
            if (rise) begin
              if (m86) begin
                state                        <= DONE;
                done_q                       <= 1'b1;
                {cascade_q, cas_oe_q, mde_q} <= 5'd0;
              end else begin
                state                        <= G2;
                cnt                          <= '0;
                {cascade_q, cas_oe_q, mde_q} <= drive(G2, hit, m86, lvl);
              end
            end
          end
          P3: begin
            if (rise) begin
              state                        <= DONE;
              done_q                       <= 1'b1;
              {cascade_q, cas_oe_q, mde_q} <= 5'd0;
            end
          end
          DONE: begin
            // Any fall seen here is dropped; a new sequence must start from IDLE.
            state <= IDLE;
          end
          default: begin
            state                        <= IDLE;
            {cascade_q, cas_oe_q, mde_q} <= 5'd0;
          end
        endcase
      end
    end
  end

  assign bus.CASCADE        = cascade_q;
  assign bus.CAS_OE         = cas_oe_q;
  assign bus.MASTER_DATA_EN = mde_q;
  assign bus.SEQ_DONE       = done_q;
  assign bus.SEQ_ABORT      = abort_q;

endmodule

// File: tb/tb_cascade_master_sequencer.sv
// tb/tb_cascade_master_sequencer.sv - scoreboard bench for cascade_master_sequencer

module tb_cascade_master_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cascade_master_sequencer_if bus ();

  cascade_master_sequencer #(
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int done_cnt  = 0;
  int abort_cnt = 0;
  logic [6:0] sb_q[$];

  always @(posedge clk) begin
    #2;
    if (bus.SEQ_DONE === 1'b1)  done_cnt++;
    if (bus.SEQ_ABORT === 1'b1) abort_cnt++;
  end

  // {CASCADE, CAS_OE, MASTER_DATA_EN, SEQ_DONE, SEQ_ABORT}
  function automatic logic [6:0] ev(logic [2:0] cas, logic oe, logic mde, logic d, logic a);
    return {cas, oe, mde, d, a};
  endfunction

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag);
    logic [6:0] o;
    logic [6:0] e;
    o = {bus.CASCADE, bus.CAS_OE, bus.MASTER_DATA_EN, bus.SEQ_DONE, bus.SEQ_ABORT};
    total++;
    if (sb_q.size() == 0) begin
      bad++;
      $error("FAIL %s observed=%h expected=<scoreboard empty>", tag, o);
    end else begin
      e = sb_q.pop_front();
      assert (o === e) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
    end
  endtask

  task automatic check_int(input string tag, input int o, input int e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  // Full sequence: pulse count from the mode; expectations from the latched inputs.
  task automatic run_seq(input logic m86, input logic [7:0] icw3, input logic [2:0] lvl,
                         input logic valid, input logic en, input logic scramble, input string tag);
    logic [2:0] l_eff;
    logic       h;
    int         np;
    int         d0;
    int         a0;
    l_eff = valid ? lvl : 3'd7;
    h     = en & valid & icw3[lvl];
    np    = m86 ? 2 : 3;
    d0    = done_cnt;
    a0    = abort_cnt;
    bus.MODE_8086   = m86;
    bus.ICW3_SLAVES = icw3;
    bus.IR_LEVEL    = lvl;
    bus.IR_VALID    = valid;
    bus.SPEN        = en;
    for (int p = 1; p <= np; p++) begin
      if (en) sb_q.push_back(ev(h ? l_eff : 3'd0, h, (p == 1) ? ~m86 : ~h, 1'b0, 1'b0));
      else    sb_q.push_back(7'd0);
      bus.INTA_N = 1'b0;
      wait_neg(3);
      check($sformatf("%s_pulse%0d", tag, p));
      if (scramble && p == 1) begin
        bus.IR_LEVEL    = ~lvl;
        bus.ICW3_SLAVES = ~icw3;
        bus.MODE_8086   = ~m86;
        bus.IR_VALID    = ~valid;
      end
      wait_neg(1);
      bus.INTA_N = 1'b1;
      if (!en)          sb_q.push_back(7'd0);
      else if (p == np) sb_q.push_back(ev(3'd0, 1'b0, 1'b0, 1'b1, 1'b0));
      else              sb_q.push_back(ev(h ? l_eff : 3'd0, h, 1'b0, 1'b0, 1'b0));
      wait_neg(3);
      check($sformatf("%s_after%0d", tag, p));
      wait_neg(2);
    end
    sb_q.push_back(7'd0);
    check({tag, "_idle"});
    check_int({tag, "_done_count"}, done_cnt - d0, en ? 1 : 0);
    check_int({tag, "_abort_count"}, abort_cnt - a0, 0);
  endtask

  int d0;
  int a0;

  initial begin
    bus.INTA_N      = 1'b1;
    bus.SPEN        = 1'b1;
    bus.SNGL        = 1'b0;
    bus.MODE_8086   = 1'b1;
    bus.ICW3_SLAVES = 8'h00;
    bus.IR_LEVEL    = 3'd0;
    bus.IR_VALID    = 1'b0;
    reset = 1'b1;
    wait_neg(3);
    reset = 1'b0;
    sb_q.push_back(7'd0);
    check("reset_state");
    wait_neg(2);

    // 8086 with slave on IR2
    run_seq(1'b1, 8'h04, 3'd2, 1'b1, 1'b1, 1'b0, "t1_8086_slave");
    // 8086, IR5 has no slave
    run_seq(1'b1, 8'h04, 3'd5, 1'b1, 1'b1, 1'b0, "t2_8086_noslave");
    // 8080, all slaves, IR6
    run_seq(1'b0, 8'hFF, 3'd6, 1'b1, 1'b1, 1'b0, "t3_8080_slave");
    // 8086 spurious acknowledge
    run_seq(1'b1, 8'h04, 3'd2, 1'b0, 1'b1, 1'b0, "t4_spurious");
    // 8080 no slave, inputs scrambled after the first pulse
    run_seq(1'b0, 8'h04, 3'd5, 1'b1, 1'b1, 1'b1, "t5_latch");
    // SPEN low from the first fall: nothing ever asserts
    run_seq(1'b1, 8'hFF, 3'd3, 1'b1, 1'b0, 1'b0, "t6_spen_off");
    bus.SPEN = 1'b1;
    wait_neg(2);

    // Gap timeout in G1
    d0 = done_cnt;
    a0 = abort_cnt;
    bus.MODE_8086 = 1'b1; bus.ICW3_SLAVES = 8'h04; bus.IR_LEVEL = 3'd2; bus.IR_VALID = 1'b1;
    sb_q.push_back(ev(3'd2, 1'b1, 1'b0, 1'b0, 1'b0));
    bus.INTA_N = 1'b0;
    wait_neg(3);
    check("to_p1");
    wait_neg(1);
    bus.INTA_N = 1'b1;
    sb_q.push_back(ev(3'd2, 1'b1, 1'b0, 1'b0, 1'b0));
    wait_neg(3);
    check("to_g1_entry");
    sb_q.push_back(ev(3'd2, 1'b1, 1'b0, 1'b0, 1'b0));
    wait_neg(15);
    check("to_g1_cycle16");
    sb_q.push_back(ev(3'd0, 1'b0, 1'b0, 1'b0, 1'b1));
    wait_neg(1);
    check("to_abort");
    sb_q.push_back(7'd0);
    wait_neg(1);
    check("to_after_abort");
    check_int("to_abort_count", abort_cnt - a0, 1);
    check_int("to_done_count", done_cnt - d0, 0);
    wait_neg(2);

    // Async reset while in P2
    d0 = done_cnt;
    sb_q.push_back(ev(3'd2, 1'b1, 1'b0, 1'b0, 1'b0));
    bus.INTA_N = 1'b0;
    wait_neg(3);
    check("rst_p1");
    wait_neg(1);
    bus.INTA_N = 1'b1;
    wait_neg(5);
    sb_q.push_back(ev(3'd2, 1'b1, 1'b0, 1'b0, 1'b0));
    bus.INTA_N = 1'b0;
    wait_neg(3);
    check("rst_p2");
    #2;
    reset = 1'b1;
    #1;
    sb_q.push_back(7'd0);
    check("rst_immediate");
    bus.INTA_N = 1'b1;
    wait_neg(3);
    reset = 1'b0;
    wait_neg(4);
    check_int("rst_done_count", done_cnt - d0, 0);

    // SPEN dropped mid-sequence (8080, slave on IR6)
    d0 = done_cnt;
    bus.MODE_8086 = 1'b0; bus.ICW3_SLAVES = 8'hFF; bus.IR_LEVEL = 3'd6; bus.IR_VALID = 1'b1;
    sb_q.push_back(ev(3'd6, 1'b1, 1'b1, 1'b0, 1'b0));
    bus.INTA_N = 1'b0;
    wait_neg(3);
    check("spen_drop_p1");
    bus.SPEN = 1'b0;
    sb_q.push_back(7'd0);
    wait_neg(1);
    check("spen_drop_idle");
    bus.INTA_N = 1'b1;
    wait_neg(5);
    bus.SPEN = 1'b1;
    wait_neg(2);
    check_int("spen_drop_done_count", done_cnt - d0, 0);

    // Recovery after all of the above
    run_seq(1'b1, 8'h80, 3'd7, 1'b1, 1'b1, 1'b0, "t7_recover");

    check_int("scoreboard_drained", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
